fetch_pq: RTL and testbench

- Parametrised prefetching fetch unit; successor to `fetch`.
- Decouples instruction-cache latency from decode using a DEPTH-entry instruction queue.
- Keeps at most one cache request in flight. Discards stale responses after a redirect.
- Presents one `{pc, inst}` per cycle to decode, or a NOP bubble. Sits between `icache` and decode, driven by the hazard unit.

---
 rtl/fetch_pq_if.sv | 43 ++++
 rtl/fetch_pq.sv | 141 ++++++++++++++
 tb/tb_fetch_pq.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pq_if.sv
// rtl/fetch_pq_if.sv - icache and decode-side signal bundle for fetch_pq
//
// Purpose: groups the icache request/response signals, the hazard-unit
// redirect/stall controls and the decode-facing final_* register into one
// interface so fetch_pq and its environment connect through a single port.
// XLEN must match the XLEN of the fetch_pq instance it is bound to.
//
// Signals:
//   cache_ack   icache -> fetch   one-cycle response strobe
//   inst        icache -> fetch   instruction, valid while cache_ack=1
//   addr_ready  fetch  -> icache  one-cycle request pulse
//   addr        fetch  -> icache  request address, stable until its ack
//   stall       hazard -> fetch   decode cannot accept, hold final_*
//   jal/branch  hazard -> fetch   redirect requests
//   j_target/b_target             redirect targets
//   final_pc/final_inst/final_valid  fetch -> decode
// Modports: master = fetch unit, slave = surrounding icache/decode/hazard logic.
interface fetch_pq_if #(
  parameter int XLEN = 32
);
  logic            cache_ack;
  logic [XLEN-1:0] inst;
  logic            addr_ready;
  logic [XLEN-1:0] addr;
  logic            stall;
  logic            jal;
  logic            branch;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] b_target;
  logic [XLEN-1:0] final_pc;
  logic [XLEN-1:0] final_inst;
  logic            final_valid;

  modport master (
    input  cache_ack, inst, stall, jal, branch, j_target, b_target,
    output addr_ready, addr, final_pc, final_inst, final_valid
  );

  modport slave (
    output cache_ack, inst, stall, jal, branch, j_target, b_target,
    input  addr_ready, addr, final_pc, final_inst, final_valid
  );
endinterface

// File: rtl/fetch_pq.sv
// rtl/fetch_pq.sv - prefetching fetch unit with DEPTH-entry instruction queue
//
// Purpose: issues at most one icache request at a time, buffers responses in
// a circular queue and presents one {pc, inst} per cycle (or a NOP bubble) to
// decode. Redirects flush the queue, retarget fetch and drop any stale
// in-flight response; further redirects are locked out until the first
// instruction at the new target reaches final_*.
//
// Ports:
//   clk   clock, all state changes on posedge
//   rst   synchronous active-low reset
//   bus   fetch_pq_if.master (icache request/response, stall/redirect, final_*)
//
// Optional feature: define FETCH_BYPASS_EN to let a response that arrives
// with the queue empty and decode ready load final_* directly at the ack edge.
module fetch_pq #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = 32'h00000013
) (
  input logic         clk,
  input logic         rst,
  fetch_pq_if.master  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

  state_t          state, state_nx;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] lock_pc;
  logic            lock;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [CW-1:0]   count;

  logic            redirect;
  logic [XLEN-1:0] target;
  logic            launch;
  logic            ack_take;
  logic            bypass;
  logic            push;
  logic            pop;

  assign redirect = (bus.jal | bus.branch) & ~lock;
  assign target   = bus.jal ? {bus.j_target[XLEN-1:2], 2'b00}
                            : {bus.b_target[XLEN-1:2], 2'b00};
  assign launch   = (state == IDLE) && !redirect && (count < CW'(DEPTH));
  // A response is only kept when it belongs to the current fetch stream:
  // a redirect in the same cycle makes it stale.
  assign ack_take = (state == WAIT) && bus.cache_ack && !redirect;
`ifdef FETCH_BYPASS_EN
  assign bypass   = ack_take && (count == '0) && !bus.stall;
`else
  assign bypass   = 1'b0;
`endif
  assign push     = ack_take && !bypass;
  assign pop      = !redirect && !bus.stall && (count != '0);

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = WAIT;
      // ack wins over redirect: the response is discarded but nothing is
      // left in flight, so there is nothing to drop.
      WAIT:    if (bus.cache_ack) state_nx = IDLE;
               else if (redirect) state_nx = DROP;
      DROP:    if (bus.cache_ack) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Queue storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[tail]   <= bus.addr;
      inst_mem[tail] <= bus.inst;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_pc        <= RESET_PC;
      lock            <= 1'b0;
      lock_pc         <= '0;
      head            <= '0;
      tail            <= '0;
      count           <= '0;
      bus.addr_ready  <= 1'b0;
      bus.addr        <= '0;
      bus.final_pc    <= '0;
      bus.final_inst  <= NOP;
      bus.final_valid <= 1'b0;
    end else begin
      bus.addr_ready <= launch;
      if (launch)   bus.addr <= fetch_pc;
      if (ack_take) fetch_pc <= bus.addr + XLEN'(4);
      if (push)     tail     <= tail + PW'(1);

      if (redirect) begin
        fetch_pc        <= target;
        lock            <= 1'b1;
        lock_pc         <= target;
        head            <= '0;
        tail            <= '0;
        count           <= '0;
        bus.final_pc    <= '0;
        bus.final_inst  <= NOP;
        bus.final_valid <= 1'b0;
      end else begin
        count <= count + CW'(push) - CW'(pop);
        if (!bus.stall) begin
          if (pop) begin
            bus.final_pc    <= pc_mem[head];
            bus.final_inst  <= inst_mem[head];
            bus.final_valid <= 1'b1;
            head            <= head + PW'(1);
            if (lock && (pc_mem[head] == lock_pc)) lock <= 1'b0;
          end else if (bypass) begin
            bus.final_pc    <= bus.addr;
            bus.final_inst  <= bus.inst;
            bus.final_valid <= 1'b1;
            if (lock && (bus.addr == lock_pc)) lock <= 1'b0;
          end else begin
            bus.final_pc    <= '0;
            bus.final_inst  <= NOP;
            bus.final_valid <= 1'b0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_fetch_pq.sv
// tb/tb_fetch_pq.sv - self-checking bench for fetch_pq
module tb_fetch_pq;
  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h00000013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_pq_if #(.XLEN(XLEN)) bus();

  fetch_pq #(.XLEN(XLEN), .DEPTH(4), .RESET_PC(32'h0), .NOP(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          lat;
    int          delay;
    logic        jal;
    logic        branch;
    logic [31:0] jt;
    logic [31:0] bt;
    logic [31:0] exp_pc;
  } rd_vec_t;

  rd_vec_t     tab [6];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat   = 1;
  logic        pend  = 1'b0;
  int          cnt   = 0;
  logic [31:0] paddr = '0;
  logic [31:0] last_valid_pc = '0;
  int          pulses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: advance the icache model (inst = addr) and sample outputs.
  task automatic tick();
    logic rst_at_edge;
    rst_at_edge = rst;
    @(posedge clk);
    #1;
    if (!rst_at_edge) begin
      pend          = 1'b0;
      bus.cache_ack = 1'b0;
    end else begin
      bus.cache_ack = 1'b0;
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.cache_ack = 1'b1;
          bus.inst      = paddr;
          pend          = 1'b0;
        end
      end
      if (bus.addr_ready) begin
        pend  = 1'b1;
        paddr = bus.addr;
        cnt   = lat;
        pulses++;
      end
    end
    if (bus.final_valid) last_valid_pc = bus.final_pc;
  endtask

  task automatic do_reset();
    rst        = 1'b0;
    bus.stall  = 1'b0;
    bus.jal    = 1'b0;
    bus.branch = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_valid(input string name, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.final_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: final_valid stayed 0, required 1 within 80 cycles", name);
    end
  endtask

  initial begin
    logic        ok;
    logic        held_bad;
    logic [31:0] sp, si, base;
    logic        sv;
    int          n;

    tab[0] = '{4, 2,  1'b1, 1'b0, 32'h08,  32'h00,  32'h08};   // jal in WAIT on a miss
    tab[1] = '{1, 3,  1'b1, 1'b1, 32'h48,  32'h44,  32'h48};   // both asserted, jal wins
    tab[2] = '{1, 5,  1'b0, 1'b1, 32'h80,  32'h44,  32'h44};   // branch only
    tab[3] = '{1, 2,  1'b1, 1'b0, 32'h4B,  32'h00,  32'h48};   // same cycle as ack, low bits cleared
    tab[4] = '{4, 4,  1'b0, 1'b1, 32'h00,  32'h1E,  32'h1C};   // branch in WAIT, low bits cleared
    tab[5] = '{1, 10, 1'b1, 1'b0, 32'h100, 32'h00,  32'h100};  // flush with entries in flight

    bus.cache_ack = 1'b0;
    bus.inst      = '0;
    bus.j_target  = '0;
    bus.b_target  = '0;

    // Reset state
    lat = 1;
    do_reset();
    chk("reset_addr_ready", {31'b0, bus.addr_ready}, 32'h0);
    chk("reset_addr", bus.addr, 32'h0);
    chk("reset_final_pc", bus.final_pc, 32'h0);
    chk("reset_final_inst", bus.final_inst, NOP);
    chk("reset_final_valid", {31'b0, bus.final_valid}, 32'h0);
    rst = 1'b1;

    // Sequential fetch 0x0 .. 0x5C
    for (int k = 0; k < 24; k++) begin
      wait_valid("seq_valid", ok);
      if (!ok) break;
      chk("seq_pc", bus.final_pc, 32'(4 * k));
      chk("seq_inst", bus.final_inst, 32'(4 * k));
    end

    // Redirect vectors
    for (int i = 0; i < 6; i++) begin
      lat = tab[i].lat;
      do_reset();
      rst = 1'b1;
      repeat (tab[i].delay) tick();
      bus.jal      = tab[i].jal;
      bus.branch   = tab[i].branch;
      bus.j_target = tab[i].jt;
      bus.b_target = tab[i].bt;
      tick();
      bus.jal    = 1'b0;
      bus.branch = 1'b0;
      wait_valid("redir_valid", ok);
      if (ok) begin
        chk("redir_pc", bus.final_pc, tab[i].exp_pc);
        chk("redir_inst", bus.final_inst, tab[i].exp_pc);
      end
    end

    // Repeated redirect while locked: second jal ignored
    lat = 1;
    do_reset();
    rst = 1'b1;
    repeat (4) tick();
    bus.jal = 1'b1;
    bus.j_target = 32'h44;
    tick();
    bus.j_target = 32'h48;
    tick();
    bus.jal = 1'b0;
    wait_valid("lock_valid0", ok);
    if (ok) chk("lock_pc0", bus.final_pc, 32'h44);
    wait_valid("lock_valid1", ok);
    if (ok) chk("lock_pc1", bus.final_pc, 32'h48);

    // Long stall: outputs held, requests stop, stream resumes contiguously
    lat = 1;
    do_reset();
    rst = 1'b1;
    repeat (10) tick();
    sp = bus.final_pc;
    si = bus.final_inst;
    sv = bus.final_valid;
    held_bad = 1'b0;
    bus.stall = 1'b1;
    for (int j = 0; j < 20; j++) begin
      if (j == 14) pulses = 0;
      tick();
      if (bus.final_pc !== sp || bus.final_inst !== si || bus.final_valid !== sv)
        held_bad = 1'b1;
    end
    chk("stall_hold", {31'b0, held_bad}, 32'h0);
    chk("stall_no_req", 32'(pulses), 32'h0);
    bus.stall = 1'b0;
    base = last_valid_pc;
    for (int k = 1; k <= 8; k++) begin
      wait_valid("stall_valid", ok);
      if (!ok) break;
      chk("stall_resume_pc", bus.final_pc, base + 32'(4 * k));
    end

    // Reset while a miss is outstanding
    lat = 4;
    do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("midrst_addr_ready", {31'b0, bus.addr_ready}, 32'h0);
    chk("midrst_addr", bus.addr, 32'h0);
    chk("midrst_final_pc", bus.final_pc, 32'h0);
    chk("midrst_final_inst", bus.final_inst, NOP);
    chk("midrst_final_valid", {31'b0, bus.final_valid}, 32'h0);
    rst = 1'b1;
    wait_valid("midrst_valid", ok);
    if (ok) begin
      chk("midrst_first_pc", bus.final_pc, 32'h0);
      chk("midrst_first_inst", bus.final_inst, 32'h0);
    end

    // Fill latency from ack edge to final_valid
    lat = 1;
    do_reset();
    rst = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.cache_ack) begin
        ok = 1'b1;
        break;
      end
    end
    n = 0;
    if (ok) begin
      for (int i = 0; i < 10; i++) begin
        tick();
        n++;
        if (bus.final_valid) break;
      end
    end
`ifdef FETCH_BYPASS_EN
    chk("fill_latency", 32'(n), 32'd1);
`else
    chk("fill_latency", 32'(n), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
